// File: rtl/seqdet_stim_ctrl.sv
// Stimulus sequencer for the serial pattern detector: clears the detector, plays
// a latched word LSB-first on det_x, and tallies the hits reported on det_y.
module seqdet_stim_ctrl #(
  parameter int SEQ_W = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEQ_W-1:0] seq_in,
  input  logic [CNT_W-1:0] len_in,
  input  logic             det_y,
  output logic             det_x,
  output logic             det_rst,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] first_hit,
  output logic             hit_valid
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] SEQ_N = CNT_W'(SEQ_W);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state, state_nx;
  logic [SEQ_W-1:0] sh;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] r;
  logic             sample;
  logic [CNT_W-1:0] sample_k;
  logic             last_bit;

  assign last_bit = (r == n - ONE);
  assign det_rst  = rst | (state == S_CLR);
  assign busy     = (state == S_CLR) | (state == S_RUN) | (state == S_DRAIN);
  assign done     = (state == S_DONE);

  // det_y lags det_x by one cycle, so RUN cycle r reports bit r-1 and DRAIN reports bit N-1.
  always_comb begin
    state_nx = state;
    sample   = 1'b0;
    sample_k = '0;
    case (state)
      S_IDLE:  if (start) state_nx = S_CLR;
      S_CLR:   state_nx = S_RUN;
      S_RUN: begin
        if (r != '0) begin
          sample   = det_y;
          sample_k = r - ONE;
        end
        if (last_bit) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        sample   = det_y;
        sample_k = n - ONE;
        state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sh        <= '0;
      n         <= '0;
      r         <= '0;
      det_x     <= 1'b0;
      hit_count <= '0;
      first_hit <= '0;
      hit_valid <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            sh        <= seq_in;
            n         <= (len_in == '0 || len_in > SEQ_N) ? SEQ_N : len_in;
            hit_count <= '0;
            first_hit <= '0;
            hit_valid <= 1'b0;
          end
        end
        S_CLR: begin
          // det_x is registered, so bit 0 is loaded while leaving CLR.
          det_x <= sh[0];
          sh    <= sh >> 1;
          r     <= '0;
        end
        S_RUN: begin
          r <= r + ONE;
          if (last_bit) begin
            det_x <= 1'b0;
          end else begin
            det_x <= sh[0];
            sh    <= sh >> 1;
          end
        end
        default: det_x <= 1'b0;
      endcase
      if (sample) begin
        if (hit_count != '1) hit_count <= hit_count + ONE;
        if (!hit_valid) begin
          first_hit <= sample_k;
          hit_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seqdet_stim_ctrl.sv
// Scoreboard bench for seqdet_stim_ctrl, with a 001/110 Moore detector as the load.
module tb_seqdet_stim_ctrl;

  localparam int SEQ_W = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [SEQ_W-1:0] seq_in;
  logic [CNT_W-1:0] len_in;
  logic             det_y;
  logic             det_x;
  logic             det_rst;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] first_hit;
  logic             hit_valid;

  seqdet_stim_ctrl #(.SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_in(seq_in), .len_in(len_in),
    .det_y(det_y), .det_x(det_x), .det_rst(det_rst), .busy(busy), .done(done),
    .hit_count(hit_count), .first_hit(first_hit), .hit_valid(hit_valid)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Detector load: y=1 when the last three bits since reset were 0,0,1 or 1,1,0
  logic [2:0] hist;
  logic [1:0] fill;
  always @(posedge clk) begin
    if (det_rst) begin
      hist <= 3'b000;
      fill <= 2'd0;
    end else begin
      hist <= {hist[1:0], det_x};
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end
  assign det_y = (fill == 2'd3) && (hist == 3'b001 || hist == 3'b110);

  typedef struct packed {
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] fh;
    logic             hv;
    logic [31:0]      cyc;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int play_len(input logic [CNT_W-1:0] len);
    return (len == 0 || len > SEQ_W) ? SEQ_W : int'(len);
  endfunction

  // Reference: count windows (b[k-2],b[k-1],b[k]) equal to 001 or 110
  function automatic exp_t model(input logic [SEQ_W-1:0] s, input logic [CNT_W-1:0] len);
    exp_t e;
    int   n, hits, first;
    bit   seen;
    logic [2:0] w;
    n = play_len(len);
    hits = 0; first = 0; seen = 0;
    for (int k = 2; k < n; k++) begin
      w = {s[k-2], s[k-1], s[k]};
      if (w == 3'b001 || w == 3'b110) begin
        if (hits < (1 << CNT_W) - 1) hits++;
        if (!seen) begin
          first = k;
          seen  = 1;
        end
      end
    end
    e.hc  = CNT_W'(hits);
    e.fh  = CNT_W'(first);
    e.hv  = seen;
    e.cyc = '0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding run
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      check("done_pending", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("hit_count", hit_count, e.hc);
        check("first_hit", first_hit, e.fh);
        check("hit_valid", hit_valid, e.hv);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300 && (busy || done); i++) @(negedge clk);
    check("idle_before_start", busy | done, 0);
  endtask

  task automatic issue(input logic [SEQ_W-1:0] s, input logic [CNT_W-1:0] len);
    exp_t e;
    wait_idle();
    seq_in = s;
    len_in = len;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    seq_in = {$urandom, $urandom};
    len_in = CNT_W'($urandom);
    e      = model(s, len);
    e.cyc  = cyc + 32'(play_len(len)) + 2;
    q.push_back(e);
  endtask

  // Plays one run, checking det_rst/det_x/busy every cycle; poke re-asserts start at that cycle index.
  task automatic run(input logic [SEQ_W-1:0] s, input logic [CNT_W-1:0] len, input int poke);
    int n;
    logic [2:0] exp_sig;
    exp_t e;
    n = play_len(len);
    e = model(s, len);
    issue(s, len);
    for (int i = 0; i <= n + 1; i++) begin
      if (i == 0)      exp_sig = 3'b101;
      else if (i <= n) exp_sig = {1'b0, s[i-1], 1'b1};
      else             exp_sig = 3'b001;
      check("trace_rst_x_busy", {det_rst, det_x, busy}, exp_sig);
      start = (i == poke);
      if (i == poke) seq_in = {$urandom, $urandom};
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_in_done", busy, 0);
    @(negedge clk);
    check("hold_count", hit_count, e.hc);
    check("all_runs_done", q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {det_x, busy, done, hit_count, first_hit, hit_valid}, '0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seq_in = '0; len_in = '0;
    repeat (2) @(negedge clk);
    check("det_rst_in_reset", det_rst, 1);
    check_reset_outputs("reset_values");
    rst = 1'b0;
    @(negedge clk);
    check("det_rst_idle", det_rst, 0);

    run(64'd4, 7'd3, -1);
    run(64'd3, 7'd3, -1);
    run(64'd12, 7'd5, -1);
    run(64'd0, 7'd0, -1);
    run(64'd12, 7'd5, 2);
    run(64'h6666_6666_6666_6666, 7'd64, 30);
    run({$urandom, $urandom}, 7'd1, -1);
    run({$urandom, $urandom}, 7'd2, -1);
    run(64'h0000_0000_0000_0001, 7'd3, -1);
    run({$urandom, $urandom}, 7'd65, -1);
    run({$urandom, $urandom}, 7'd127, -1);

    // Reset while idle clears held results
    run(64'h1c, 7'd8, -1);
    rst = 1'b1;
    #1 check("det_rst_idle_reset", det_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs("idle_reset_clears");

    // Reset at RUN r=2 abandons the run without a done pulse
    issue(64'd4, 7'd3);
    repeat (3) @(negedge clk);
    check("in_run_before_rst", busy, 1);
    q.delete();
    rst = 1'b1;
    #1 check("det_rst_midrun", det_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs("midrun_reset_values");
    check("det_rst_after_reset", det_rst, 0);
    repeat (8) @(negedge clk);
    run(64'd4, 7'd3, -1);

    for (int t = 0; t < 20; t++) begin
      run({$urandom, $urandom}, CNT_W'($urandom_range(0, 127)),
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 70)) : -1);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
